// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: instruction classes, FSM states
// and the decoder instruction ids the class map understands.
package mc_ctrl_pkg;

  localparam int CLS_BITS = 4;
  localparam int ID_W     = 6;

  localparam logic [3:0] CLS_NOP     = 4'd0;
  localparam logic [3:0] CLS_ALU_R   = 4'd1;
  localparam logic [3:0] CLS_ALU_I   = 4'd2;
  localparam logic [3:0] CLS_LUI     = 4'd3;
  localparam logic [3:0] CLS_LOAD    = 4'd4;
  localparam logic [3:0] CLS_STORE   = 4'd5;
  localparam logic [3:0] CLS_BRANCH  = 4'd6;
  localparam logic [3:0] CLS_JUMP    = 4'd7;
  localparam logic [3:0] CLS_JAL     = 4'd8;
  localparam logic [3:0] CLS_JR      = 4'd9;
  localparam logic [3:0] CLS_ILLEGAL = 4'd15;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_TRAP   = 3'd7;

  // Decoder instruction ids; anything not listed maps to CLS_ILLEGAL.
  localparam logic [ID_W-1:0] ID_NOP  = 6'd0;
  localparam logic [ID_W-1:0] ID_ADDU = 6'd1;
  localparam logic [ID_W-1:0] ID_SUBU = 6'd2;
  localparam logic [ID_W-1:0] ID_ORI  = 6'd3;
  localparam logic [ID_W-1:0] ID_LUI  = 6'd4;
  localparam logic [ID_W-1:0] ID_LW   = 6'd5;
  localparam logic [ID_W-1:0] ID_SW   = 6'd6;
  localparam logic [ID_W-1:0] ID_BEQ  = 6'd7;
  localparam logic [ID_W-1:0] ID_J    = 6'd8;
  localparam logic [ID_W-1:0] ID_JAL  = 6'd9;
  localparam logic [ID_W-1:0] ID_JR   = 6'd10;
  localparam logic [ID_W-1:0] ID_ADDI = 6'd11;

endpackage

// File: rtl/mc_cls_map.sv
// Combinational map from decoder instruction id to controller instruction class.
// Zero latency; no flow control.
module mc_cls_map
  import mc_ctrl_pkg::*;
(
  input  logic [ID_W-1:0]     instrId,
  output logic [CLS_BITS-1:0] cls
);

  always_comb begin
    cls = CLS_ILLEGAL;
    case (instrId)
      ID_NOP:           cls = CLS_NOP;
      ID_ADDU, ID_SUBU: cls = CLS_ALU_R;
      ID_ORI, ID_ADDI:  cls = CLS_ALU_I;
      ID_LUI:           cls = CLS_LUI;
      ID_LW:            cls = CLS_LOAD;
      ID_SW:            cls = CLS_STORE;
      ID_BEQ:           cls = CLS_BRANCH;
      ID_J:             cls = CLS_JUMP;
      ID_JAL:           cls = CLS_JAL;
      ID_JR:            cls = CLS_JR;
      default:          cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS sequencing FSM: datapath strobes, memory req/ack, retired counter.
// 2-5 cycles per instruction; im_ack/dm_ack waits stretch FETCH/MEM one cycle each.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CLS_W = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CLS_W-1:0] cls,
  input  logic             im_ack,
  input  logic             dm_ack,
  output logic             im_req,
  output logic             dm_req,
  output logic             dm_we,
  output logic             ir_we,
  output logic             ab_we,
  output logic             alu_we,
  output logic             mdr_we,
  output logic             grf_we,
  output logic             pc_we,
  output logic             trap,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  logic [2:0]       stateQ;
  logic [2:0]       stateNext;
  logic [CNT_W-1:0] retiredQ;

  always_comb begin
    stateNext = stateQ;
    im_req    = 1'b0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    ir_we     = 1'b0;
    ab_we     = 1'b0;
    alu_we    = 1'b0;
    mdr_we    = 1'b0;
    grf_we    = 1'b0;
    pc_we     = 1'b0;
    case (stateQ)
      ST_FETCH: begin
        im_req = 1'b1;
        if (im_ack) begin
          ir_we     = 1'b1;
          stateNext = ST_DECODE;
        end
      end
      ST_DECODE: begin
        ab_we = 1'b1;
        case (cls)
          CLS_NOP, CLS_BRANCH, CLS_JUMP, CLS_JR: begin
            pc_we     = 1'b1;
            stateNext = ST_FETCH;
          end
          CLS_JAL:                                            stateNext = ST_WB;
          CLS_ALU_R, CLS_ALU_I, CLS_LUI, CLS_LOAD, CLS_STORE: stateNext = ST_EXEC;
          default:                                            stateNext = ST_TRAP;
        endcase
      end
      ST_EXEC: begin
        alu_we = 1'b1;
        case (cls)
          CLS_LOAD, CLS_STORE:           stateNext = ST_MEM;
          CLS_ALU_R, CLS_ALU_I, CLS_LUI: stateNext = ST_WB;
          default:                       stateNext = ST_TRAP;
        endcase
      end
      ST_MEM: begin
        dm_req = 1'b1;
        dm_we  = (cls == CLS_STORE);
        if (dm_ack && cls == CLS_STORE) begin
          pc_we     = 1'b1;
          stateNext = ST_FETCH;
        end else if (dm_ack && cls == CLS_LOAD) begin
          mdr_we    = 1'b1;
          stateNext = ST_WB;
        end
      end
      // JAL also lands here: PC takes the jump target while GRF takes PC+4.
      ST_WB: begin
        grf_we    = 1'b1;
        pc_we     = 1'b1;
        stateNext = ST_FETCH;
      end
      ST_TRAP: stateNext = ST_TRAP;
      default: stateNext = ST_TRAP;
    endcase

    // A reset cycle must never leak a partial write into GRF, DM or PC.
    if (rst) begin
      im_req = 1'b0;
      dm_req = 1'b0;
      dm_we  = 1'b0;
      ir_we  = 1'b0;
      ab_we  = 1'b0;
      alu_we = 1'b0;
      mdr_we = 1'b0;
      grf_we = 1'b0;
      pc_we  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ   <= ST_FETCH;
      retiredQ <= '0;
    end else begin
      stateQ <= stateNext;
      if (pc_we) retiredQ <= retiredQ + CNT_W'(1);
    end
  end

  assign trap    = (stateQ == ST_TRAP);
  assign state   = stateQ;
  assign retired = retiredQ;

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle sequencing controller for the MIPS-32 datapath: PC, IM, decoder, GRF, COMP, ALU, DM and write-back.
- Replaces the single-cycle "everything every clock" scheme with a per-instruction state machine. It issues write-enables and latch strobes for PC, IR, A/B operand latches, ALUOut latch, MDR and GRF.
- Handshakes with instruction and data memory through req/ack pairs.
- Sits beside the datapath in the top-level CPU, fed by an instruction-class code derived from the decoder's instruction id.

Parameters:
CLS_W, 4, width of instruction-class code
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
cls  input  CLS_W  instruction class of the IR contents, valid from DECODE onward (encoding in package)
im_ack  input  1  instruction memory done; IR data valid this cycle
dm_ack  input  1  data memory access done; load data valid this cycle
im_req  output  1  instruction fetch request
dm_req  output  1  data memory request
dm_we  output  1  data memory write (qualifies dm_req)
ir_we  output  1  latch instruction register
ab_we  output  1  latch Rs/Rt read data into A/B
alu_we  output  1  latch ALU result
mdr_we  output  1  latch memory read data
grf_we  output  1  register-file write
pc_we  output  1  load PC from NPC (next or target, selected by NPC/COMP)
trap  output  1  sticky illegal-instruction flag
state  output  3  current state, for debug and bench
retired  output  CNT_W  count of completed instructions

Behaviour:
- All state updates on posedge clk. rst high:
  - state <= FETCH, trap <= 0, retired <= 0.
  - All strobe outputs forced 0 during the rst cycle, regardless of state.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- Outputs are Moore decodes of state, except strobes qualified by ack, which are Mealy (same cycle as ack).
- FETCH:
  - im_req=1.
  - On im_ack: ir_we=1, go to DECODE. Otherwise stay in FETCH; im_req held high.
- DECODE: ab_we=1. Next state by cls:
  - JUMP, JR, BRANCH, NOP: pc_we=1, go to FETCH. For BRANCH, the branch decision is taken from COMP in this cycle.
  - JAL: go to WB.
  - ALU_R, ALU_I, LUI, LOAD, STORE: go to EXEC.
  - ILLEGAL or any unlisted code: go to TRAP. No pc_we.
- EXEC:
  - alu_we=1.
  - LOAD or STORE: go to MEM.
  - ALU_R, ALU_I, LUI: go to WB.
- MEM:
  - dm_req=1; dm_we=1 when cls=STORE.
  - STORE with dm_ack: pc_we=1, go to FETCH.
  - LOAD with dm_ack: mdr_we=1, go to WB.
  - No ack: hold state; req and we stay stable.
- WB:
  - grf_we=1 and pc_we=1, go to FETCH.
  - For JAL, pc_we loads the jump target; the write-back mux supplies PC+4.
- TRAP:
  - trap=1, all strobes 0.
  - Held until rst.
- retired increments by 1 in every cycle where pc_we=1. Wraps modulo 2^CNT_W without saturation.
- Acks arriving outside their request state are ignored. Acks may arrive in the same cycle as the request.
- Minimum latencies with zero-wait acks:
  - ALU: 4 cycles
  - LOAD: 5 cycles
  - STORE: 4 cycles
  - BRANCH/J/JR/NOP: 2 cycles
  - JAL: 3 cycles
- Each wait cycle on im_ack or dm_ack adds exactly 1 cycle.
- Exactly one pc_we pulse per non-trapping instruction. grf_we and dm_we are never asserted in the same cycle.
- cls must be stable from DECODE until return to FETCH, since the IR is unchanged during that span.
- rst asserted mid-instruction (any state, including MEM awaiting ack): next state FETCH, no partial GRF or DM write in the rst cycle.

Decomposition:
- Shared package/include (beside the instruction definitions) holds:
  - cls encodings: NOP=0, ALU_R=1, ALU_I=2, LUI=3, LOAD=4, STORE=5, BRANCH=6, JUMP=7, JAL=8, JR=9, ILLEGAL=15.
  - State encodings.
- One natural sub-module: mc_cls_map, a combinational map from decoder instruction id to cls.
- Counter and FSM stay inside mc_ctrl.

Test Plan:
- Reset then ALU_R, zero-wait acks -> ir_we@c0, ab_we@c1, alu_we@c2, grf_we+pc_we@c3; retired=1.
- LOAD with dm_ack delayed 3 cycles -> dm_req high 4 cycles with dm_we=0; mdr_we on ack cycle; grf_we next cycle; total 8 cycles.
- STORE then BRANCH -> dm_req+dm_we with pc_we on ack, no grf_we; BRANCH pc_we in DECODE after 2 cycles; retired=2.
- JAL -> FETCH, DECODE, WB; grf_we and pc_we together in WB; 3 cycles.
- cls=ILLEGAL (15) -> TRAP after DECODE; trap=1; no strobes for 20 cycles; rst returns to FETCH with trap=0, retired=0.
- rst pulsed while in MEM awaiting dm_ack, with stray im_ack/dm_ack pulses in wrong states -> no dm_we/grf_we after the reset cycle; state=FETCH; stray acks produce no strobes.
